vga_line_sched: RTL and testbench

VGA_LINE_SCHED -- requirements
Module: vga_line_sched

---
 rtl/vga_pkg.sv | 16 +
 rtl/vga_line_sched_if.sv | 33 +++
 rtl/vga_line_sched_line_ram.sv | 35 +++
 rtl/vga_line_sched.sv | 146 ++++++++++++++
 tb/tb_vga_line_sched.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared FSM state enum, size defaults and pixel type for the VGA line scheduler
package vga_pkg;

    localparam int LINE_PIX_DEF = 256;
    localparam int PIX_W_DEF    = 15;

    typedef logic [PIX_W_DEF-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_SYNC = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

endpackage

// File: rtl/vga_line_sched_if.sv
// rtl/vga_line_sched_if.sv - PPU write side and VGA read side bundle (overrun_count only with VGA_SCHED_STATS_EN)
interface vga_line_sched_if #(
    parameter int PIX_W = vga_pkg::PIX_W_DEF
);
    logic             ppu_pix_valid;
    logic [PIX_W-1:0] ppu_pix_data;
    logic             ppu_line_end;
    logic             ppu_frame_start;
    logic [9:0]       next_pixel_x;
    logic [PIX_W-1:0] pixel;
    logic             sync;
    logic             locked;
    logic             overrun;
`ifdef VGA_SCHED_STATS_EN
    logic [15:0]      overrun_count;
`endif

    modport slave (
        input  ppu_pix_valid, ppu_pix_data, ppu_line_end, ppu_frame_start, next_pixel_x,
        output pixel, sync, locked, overrun
`ifdef VGA_SCHED_STATS_EN
        , output overrun_count
`endif
    );

    modport master (
        output ppu_pix_valid, ppu_pix_data, ppu_line_end, ppu_frame_start, next_pixel_x,
        input  pixel, sync, locked, overrun
`ifdef VGA_SCHED_STATS_EN
        , input overrun_count
`endif
    );
endinterface

// File: rtl/vga_line_sched_line_ram.sv
// rtl/vga_line_sched_line_ram.sv - two line banks, one write port, one registered read port
module line_ram #(
    parameter int LINE_PIX = vga_pkg::LINE_PIX_DEF,
    parameter int PIX_W    = vga_pkg::PIX_W_DEF,
    localparam int AW      = $clog2(LINE_PIX)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             rd_bank,
    input  logic [AW-1:0]    rd_addr,
    input  logic             rd_clr,
    output logic [PIX_W-1:0] rd_data
);
    // Bank contents are deliberately left unreset.
    logic [PIX_W-1:0] mem [0:2*LINE_PIX-1];

    // Write port: bank bit selects the upper half.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    // Read register: a colliding write is not forwarded, so old data is returned.
    always_ff @(posedge clk) begin
        if (rd_clr) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[{rd_bank, rd_addr}];
        end
    end
endmodule

// File: rtl/vga_line_sched.sv
// rtl/vga_line_sched.sv - PPU-to-VGA line double buffer scheduler; VGA_SCHED_STATS_EN adds overrun_count
module vga_line_sched
    import vga_pkg::*;
#(
    parameter int LINE_PIX = LINE_PIX_DEF,
    parameter int PIX_W    = PIX_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    vga_line_sched_if.slave    bus
);
    localparam int AW = $clog2(LINE_PIX);

    state_t        state, state_next;
    logic [AW-1:0] wr_x;
    logic          wr_bank;
    logic          sync_q;
    logic          overrun_q;
    logic          restart;
    logic          line_close;
    logic          wr_en;
    logic          ovr_event;
    logic          unused_pix_lsb;

    // Each stored pixel covers two VGA pixels, so bit 0 of the x index is dropped.
    assign unused_pix_lsb = bus.next_pixel_x[0];

    // Next state plus the write-pointer and overrun events of this cycle.
    always_comb begin
        state_next = state;
        restart    = 1'b0;
        line_close = 1'b0;
        wr_en      = 1'b0;
        ovr_event  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.ppu_frame_start) begin
                    restart    = 1'b1;
                    state_next = ST_ARM;
                end
            end
            ST_ARM: begin
                wr_en = bus.ppu_pix_valid;
                if (bus.ppu_frame_start) begin
                    restart = 1'b1;
                end else if (bus.ppu_line_end) begin
                    line_close = 1'b1;
                    state_next = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (bus.ppu_frame_start) begin
                    restart    = 1'b1;
                    state_next = ST_ARM;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                wr_en = bus.ppu_pix_valid;
                if (bus.ppu_frame_start && overrun_q) begin
                    restart    = 1'b1;
                    state_next = ST_ARM;
                end else if (bus.ppu_line_end) begin
                    line_close = 1'b1;
                    ovr_event  = (wr_bank == bus.next_pixel_x[9]);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Write pointer: restart beats line close; saturates on the last entry.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            wr_x    <= '0;
            wr_bank <= 1'b0;
        end else if (line_close) begin
            wr_x    <= '0;
            wr_bank <= ~wr_bank;
        end else if (wr_en && (wr_x != AW'(LINE_PIX - 1))) begin
            wr_x <= wr_x + 1'b1;
        end
    end

    // Sync pulse is the registered image of the single SYNC cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= (state == ST_SYNC);
        end
    end

    // Overrun is only set in RUN and only left via a restart, which clears it.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            overrun_q <= 1'b0;
        end else if (ovr_event) begin
            overrun_q <= 1'b1;
        end
    end

`ifdef VGA_SCHED_STATS_EN
    logic [15:0] ovr_cnt;

    // Saturating count of overrun events.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_cnt <= '0;
        end else if (ovr_event && (ovr_cnt != 16'hFFFF)) begin
            ovr_cnt <= ovr_cnt + 16'd1;
        end
    end

    assign bus.overrun_count = ovr_cnt;
`endif

    line_ram #(
        .LINE_PIX (LINE_PIX),
        .PIX_W    (PIX_W)
    ) u_line_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_bank (wr_bank),
        .wr_addr (wr_x),
        .wr_data (bus.ppu_pix_data),
        .rd_bank (bus.next_pixel_x[9]),
        .rd_addr (bus.next_pixel_x[AW:1]),
        .rd_clr  (reset || (state_next != ST_RUN)),
        .rd_data (bus.pixel)
    );

    assign bus.sync    = sync_q;
    assign bus.locked  = (state == ST_RUN);
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_vga_line_sched.sv
// tb/tb_vga_line_sched.sv - self-checking bench for vga_line_sched against a line-buffer reference model
module tb_vga_line_sched;
    import vga_pkg::*;

    localparam int LP = LINE_PIX_DEF;
    localparam int PW = PIX_W_DEF;
    localparam int MD_IDLE = 0;
    localparam int MD_ARM  = 1;
    localparam int MD_SYNC = 2;
    localparam int MD_RUN  = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vga_line_sched_if #(.PIX_W(PW)) bus ();

    vga_line_sched #(.LINE_PIX(LP), .PIX_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // reference model state
    int     md;
    int     mwx;
    int     mwb;
    logic   mov;
    int     mcnt;
    pixel_t mbank [2][LP];
    logic   exp_sync;
    logic   exp_locked;
    pixel_t exp_pix;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        logic       v, le, fs;
        logic [9:0] nx;
        pixel_t     d, rd;
        bit         wr_ok, closing, restart;
        v  = bus.ppu_pix_valid;
        le = bus.ppu_line_end;
        fs = bus.ppu_frame_start;
        nx = bus.next_pixel_x;
        d  = bus.ppu_pix_data;
        exp_sync = !reset && (md == MD_SYNC);
        rd = mbank[nx[9]][nx[8:1]];
        if (reset) begin
            md = MD_IDLE; mwx = 0; mwb = 0; mov = 1'b0; mcnt = 0;
        end else begin
            wr_ok   = (md == MD_ARM || md == MD_RUN) && v;
            restart = 1'b0;
            closing = 1'b0;
            if (wr_ok) mbank[mwb][mwx] = d;
            case (md)
                MD_IDLE: if (fs) begin restart = 1'b1; md = MD_ARM; end
                MD_ARM: begin
                    if (fs) restart = 1'b1;
                    else if (le) begin closing = 1'b1; md = MD_SYNC; end
                end
                MD_SYNC: begin
                    if (fs) begin restart = 1'b1; md = MD_ARM; end
                    else md = MD_RUN;
                end
                default: begin
                    if (fs && mov) begin restart = 1'b1; md = MD_ARM; end
                    else if (le) begin
                        if (mwb == int'(nx[9])) begin
                            mov = 1'b1;
                            if (mcnt < 65535) mcnt++;
                        end
                        closing = 1'b1;
                    end
                end
            endcase
            if (restart) begin mwx = 0; mwb = 0; mov = 1'b0; end
            else if (closing) begin mwx = 0; mwb = 1 - mwb; end
            else if (wr_ok && mwx < LP - 1) mwx++;
        end
        exp_locked = (md == MD_RUN);
        exp_pix    = exp_locked ? rd : '0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("sync", {31'd0, bus.sync}, {31'd0, exp_sync});
        check("locked", {31'd0, bus.locked}, {31'd0, exp_locked});
        check("overrun", {31'd0, bus.overrun}, {31'd0, mov});
        if (!$isunknown(exp_pix)) check("pixel", {17'd0, bus.pixel}, {17'd0, exp_pix});
`ifdef VGA_SCHED_STATS_EN
        check("ovr_cnt", {16'd0, bus.overrun_count}, mcnt);
`endif
    endtask

    task automatic quiet();
        bus.ppu_pix_valid   = 1'b0;
        bus.ppu_line_end    = 1'b0;
        bus.ppu_frame_start = 1'b0;
    endtask

    task automatic pulse_fs();
        bus.ppu_frame_start = 1'b1; step(); bus.ppu_frame_start = 1'b0;
    endtask

    task automatic pulse_le();
        bus.ppu_line_end = 1'b1; step(); bus.ppu_line_end = 1'b0;
    endtask

    task automatic write_line(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            bus.ppu_pix_valid = 1'b1;
            bus.ppu_pix_data  = pixel_t'(base + i);
            step();
        end
        bus.ppu_pix_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; step(); step(); reset = 1'b0;
    endtask

    initial begin
        md = MD_IDLE; mwx = 0; mwb = 0; mov = 1'b0; mcnt = 0;
        quiet();
        bus.ppu_pix_data = '0;
        bus.next_pixel_x = 10'h000;

        // reset state
        do_reset();
        check("rst_pixel", {17'd0, bus.pixel}, 32'd0);
        check("rst_sync", {31'd0, bus.sync}, 32'd0);
        check("rst_locked", {31'd0, bus.locked}, 32'd0);
        check("rst_overrun", {31'd0, bus.overrun}, 32'd0);

        // first line, lock timing
        pulse_fs();
        write_line(256, 0);
        pulse_le();
        check("lock_sync_c1", {31'd0, bus.sync}, 32'd0);
        step();
        check("lock_sync_c2", {31'd0, bus.sync}, 32'd1);
        step();
        check("lock_sync_c3", {31'd0, bus.sync}, 32'd0);
        check("lock_locked", {31'd0, bus.locked}, 32'd1);

        // pixel doubling reads
        bus.next_pixel_x = 10'h006; step();
        check("rd_x6", {17'd0, bus.pixel}, 32'd3);
        bus.next_pixel_x = 10'h007; step();
        check("rd_x7", {17'd0, bus.pixel}, 32'd3);

        // 300 pixels into one 256 entry line (bank 1)
        write_line(300, 1000);
        pulse_le();
        bus.next_pixel_x = {1'b1, 8'd0, 1'b0};   step();
        check("sat_e0", {17'd0, bus.pixel}, 32'd1000);
        bus.next_pixel_x = {1'b1, 8'd100, 1'b0}; step();
        check("sat_e100", {17'd0, bus.pixel}, 32'd1100);
        bus.next_pixel_x = {1'b1, 8'd254, 1'b0}; step();
        check("sat_e254", {17'd0, bus.pixel}, 32'd1254);
        bus.next_pixel_x = {1'b1, 8'd255, 1'b1}; step();
        check("sat_e255", {17'd0, bus.pixel}, 32'd1299);

        // overrun and recovery (wr_bank is 0 now)
        bus.next_pixel_x = 10'h000;
        pulse_le();
        check("ovr_set", {31'd0, bus.overrun}, 32'd1);
        pulse_fs();
        check("ovr_unlock", {31'd0, bus.locked}, 32'd0);
        check("ovr_clear", {31'd0, bus.overrun}, 32'd0);
        write_line(256, 77);
        pulse_le();
        step();
        step();
        check("ovr_relock", {31'd0, bus.locked}, 32'd1);

        // reset during SYNC
        do_reset();
        pulse_fs();
        pulse_le();
        reset = 1'b1; step(); reset = 1'b0;
        check("rsync_sync", {31'd0, bus.sync}, 32'd0);
        check("rsync_locked", {31'd0, bus.locked}, 32'd0);
        check("rsync_pixel", {17'd0, bus.pixel}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            bus.ppu_line_end = (i % 4 == 1);
            step();
            check("rsync_nosync", {31'd0, bus.sync}, 32'd0);
        end
        quiet();
        pulse_fs();
        pulse_le();
        step();
        check("rsync_resync", {31'd0, bus.sync}, 32'd1);

`ifdef VGA_SCHED_STATS_EN
        // three forced overruns
        do_reset();
        pulse_fs();
        pulse_le();
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            bus.next_pixel_x = {mwb[0], 9'd0};
            pulse_le();
            step();
        end
        check("stats_count3", {16'd0, bus.overrun_count}, 32'd3);
`endif

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset               = ($urandom_range(0, 599) == 0);
            bus.ppu_pix_valid   = ($urandom_range(0, 9) < 7);
            bus.ppu_pix_data    = pixel_t'($urandom);
            bus.ppu_line_end    = ($urandom_range(0, 39) == 0);
            bus.ppu_frame_start = ($urandom_range(0, 249) == 0);
            bus.next_pixel_x    = 10'($urandom);
            step();
        end
        reset = 1'b0;
        quiet();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
